// File: rtl/subband_pkg.sv
// Shared types and constants for the subband window feeder: edge and FSM
// enums, default band bases and the index-width helper.
package subband_pkg;

  typedef enum logic {
    EDGE_SKIP = 1'b0,
    EDGE_ZERO = 1'b1
  } edge_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [11:0] DEF_BASE0 = 12'd0;
  localparam logic [11:0] DEF_BASE1 = 12'd32;
  localparam logic [11:0] DEF_BASE2 = 12'd2048;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int bw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/window_out_fifo.sv
// Two-entry FIFO for finished windows; the count output lets the read issuer
// reserve space for in-flight RAM reads.
module window_out_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;

  // NOTE: registers update with <= so every flop samples pre-edge values and
  // simultaneous push/pop see a consistent count and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/subband_window_feeder.sv
// Walks NUM_BANDS subbands in round-robin raster order, reads coefficients
// from RAM and streams 3-row column windows built from per-band line buffers.
module subband_window_feeder
  import subband_pkg::*;
#(
  parameter int                          DATA_W     = 16,
  parameter int                          ADDR_W     = 12,
  parameter int                          NUM_BANDS  = 3,
  parameter logic [NUM_BANDS*ADDR_W-1:0] BAND_BASE  = {DEF_BASE2, DEF_BASE1, DEF_BASE0},
  parameter int                          BAND_W     = 32,
  parameter int                          BAND_H     = 32,
  parameter int                          ROW_STRIDE = 64,
  parameter int                          EDGE_MODE  = 0,
  localparam int                         BW         = bw(NUM_BANDS),
  localparam int                         XW         = bw(BAND_W),
  localparam int                         YW         = bw(BAND_H)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                ram_rd_en,
  output logic [ADDR_W-1:0]   ram_addr,
  input  logic [DATA_W-1:0]   ram_q,
  output logic                win_valid,
  input  logic                win_ready,
  output logic [BW-1:0]       win_band,
  output logic [XW-1:0]       win_x,
  output logic [YW-1:0]       win_y,
  output logic [3*DATA_W-1:0] win_col,
  output logic                win_last
);

  localparam edge_mode_e MODE = edge_mode_e'(EDGE_MODE[0]);

  typedef struct packed {
    logic [BW-1:0]       band;
    logic [XW-1:0]       x;
    logic [YW-1:0]       y;
    logic [3*DATA_W-1:0] col;
    logic                last;
  } win_t;

  state_e        state_q, state_d;
  logic [BW-1:0] b_q, b_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          inflight_q;
  logic [BW-1:0] rd_b_q;
  logic [XW-1:0] rd_x_q;
  logic [YW-1:0] rd_y_q;
  logic          rd_last_q;

  logic          b_end, x_end, y_end, last_pos;
  logic [1:0]    fifo_count;
  logic [2:0]    credit;
  logic          pop, push;
  win_t          push_data, head;
  logic [DATA_W-1:0] top, mid;
  logic [ADDR_W-1:0] base_sel, row_off;

  logic [DATA_W-1:0] lb0_q [NUM_BANDS][BAND_W];
  logic [DATA_W-1:0] lb1_q [NUM_BANDS][BAND_W];

  assign b_end    = (b_q == BW'(NUM_BANDS - 1));
  assign x_end    = (x_q == XW'(BAND_W - 1));
  assign y_end    = (y_q == YW'(BAND_H - 1));
  assign last_pos = b_end && x_end && y_end;

  assign win_valid = (fifo_count != 2'd0);
  assign pop       = win_valid && win_ready;
  // Reads in flight already own a FIFO slot, warm-up rows included.
  assign credit    = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (ram_rd_en && last_pos) state_d = DRAIN;
      DRAIN:   if (!inflight_q && (fifo_count == 2'd0)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == RUN) || (state_q == DRAIN);
    done      = (state_q == DONE);
    ram_rd_en = (state_q == RUN) && (credit < 3'd2);
  end

  // NOTE: every variable written here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    b_d = b_q;
    x_d = x_q;
    y_d = y_q;
    if ((state_q == IDLE) && start) begin
      b_d = '0;
      x_d = '0;
      y_d = '0;
    end else if (ram_rd_en) begin
      if (!b_end) begin
        b_d = b_q + 1'b1;
      end else begin
        b_d = '0;
        if (!x_end) begin
          x_d = x_q + 1'b1;
        end else begin
          x_d = '0;
          y_d = y_end ? '0 : y_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q        <= '0;
      x_q        <= '0;
      y_q        <= '0;
      inflight_q <= 1'b0;
      rd_b_q     <= '0;
      rd_x_q     <= '0;
      rd_y_q     <= '0;
      rd_last_q  <= 1'b0;
    end else begin
      b_q        <= b_d;
      x_q        <= x_d;
      y_q        <= y_d;
      inflight_q <= ram_rd_en;
      if (ram_rd_en) begin
        rd_b_q    <= b_q;
        rd_x_q    <= x_q;
        rd_y_q    <= y_q;
        rd_last_q <= last_pos;
      end
    end
  end

  assign base_sel = BAND_BASE[int'(b_q)*ADDR_W +: ADDR_W];
  assign row_off  = ADDR_W'(int'(y_q) * ROW_STRIDE);
  assign ram_addr = ram_rd_en ? (base_sel + row_off + ADDR_W'(x_q)) : '0;

  // NOTE: the line buffers carry no reset; edge rows are masked on output, so
  // stale contents never reach a window and the arrays stay plain storage.
  always_ff @(posedge clk) begin
    if (inflight_q) begin
      lb1_q[rd_b_q][rd_x_q] <= lb0_q[rd_b_q][rd_x_q];
      lb0_q[rd_b_q][rd_x_q] <= ram_q;
    end
  end

  always_comb begin
    top = lb1_q[rd_b_q][rd_x_q];
    mid = lb0_q[rd_b_q][rd_x_q];
    if (MODE == EDGE_ZERO) begin
      if (rd_y_q == '0) begin
        top = '0;
        mid = '0;
      end else if (rd_y_q == YW'(1)) begin
        top = '0;
      end
    end
  end

  assign push = inflight_q && ((MODE == EDGE_ZERO) || (rd_y_q >= YW'(2)));

  always_comb begin
    push_data.band = rd_b_q;
    push_data.x    = rd_x_q;
    push_data.y    = rd_y_q;
    push_data.col  = {top, mid, ram_q};
    push_data.last = rd_last_q;
  end

  window_out_fifo #(
    .WIDTH($bits(win_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (push_data),
    .data_o  (head),
    .count_o (fifo_count)
  );

  assign win_band = head.band;
  assign win_x    = head.x;
  assign win_y    = head.y;
  assign win_col  = head.col;
  assign win_last = head.last;

endmodule

// File: tb/tb_subband_window_feeder.sv
// Scoreboard bench for subband_window_feeder: one zero-pad instance and one
// skip-rows instance, each fed by a RAM model returning its read address.
module tb_subband_window_feeder;

  typedef struct {
    int          band;
    int          x;
    int          y;
    logic [47:0] col;
    bit          last;
  } exp_t;

  logic clk, rst_n;

  logic        start1, rdy1, d1_busy, d1_done, d1_rd, d1_valid, d1_band, d1_last;
  logic [11:0] d1_addr;
  logic [15:0] q1;
  logic [1:0]  d1_x, d1_y;
  logic [47:0] d1_col;

  logic        start0, rdy0, d0_busy, d0_done, d0_rd, d0_valid, d0_band, d0_last;
  logic [11:0] d0_addr;
  logic [15:0] q0;
  logic [1:0]  d0_x, d0_y;
  logic [47:0] d0_col;

  exp_t exp_w1[$], exp_w0[$];
  int   exp_a1[$], exp_a0[$];
  int   n_checks, n_errors;
  int   acc1, acc0, done1, done0, rdcnt1, stall_rd, cyc;

  subband_window_feeder #(
    .DATA_W(16), .ADDR_W(12), .NUM_BANDS(2), .BAND_BASE({12'd32, 12'd0}),
    .BAND_W(4), .BAND_H(4), .ROW_STRIDE(64), .EDGE_MODE(1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(d1_busy), .done(d1_done),
    .ram_rd_en(d1_rd), .ram_addr(d1_addr), .ram_q(q1), .win_valid(d1_valid),
    .win_ready(rdy1), .win_band(d1_band), .win_x(d1_x), .win_y(d1_y),
    .win_col(d1_col), .win_last(d1_last)
  );

  subband_window_feeder #(
    .DATA_W(16), .ADDR_W(12), .NUM_BANDS(2), .BAND_BASE({12'd32, 12'd0}),
    .BAND_W(4), .BAND_H(4), .ROW_STRIDE(64), .EDGE_MODE(0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .busy(d0_busy), .done(d0_done),
    .ram_rd_en(d0_rd), .ram_addr(d0_addr), .ram_q(q0), .win_valid(d0_valid),
    .win_ready(rdy0), .win_band(d0_band), .win_x(d0_x), .win_y(d0_y),
    .win_col(d0_col), .win_last(d0_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: data equals the address, one cycle after the read strobe.
  always @(posedge clk) begin
    if (d1_rd) q1 <= {4'b0, d1_addr};
    if (d0_rd) q0 <= {4'b0, d0_addr};
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected reads and windows for one frame, derived from raster order.
  task automatic fill(input int mode);
    exp_t e;
    int   addr;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        for (int b = 0; b < 2; b++) begin
          addr = b * 32 + y * 64 + x;
          if (mode == 1) exp_a1.push_back(addr); else exp_a0.push_back(addr);
          if (mode == 1 || y >= 2) begin
            e.band = b;
            e.x    = x;
            e.y    = y;
            e.col  = {16'((y >= 2) ? addr - 128 : 0), 16'((y >= 1) ? addr - 64 : 0), 16'(addr)};
            e.last = (y == 3 && x == 3 && b == 1);
            if (mode == 1) exp_w1.push_back(e); else exp_w0.push_back(e);
          end
        end
  endtask

  task automatic pulse_start(input int which);
    step();
    if (which == 1) start1 = 1'b1; else start0 = 1'b1;
    step();
    start1 = 1'b0;
    start0 = 1'b0;
  endtask

  task automatic wait_done(input int which, input string tag);
    int n;
    n = 0;
    while (n < 300) begin
      step();
      n++;
      if ((which == 1) ? d1_done : d0_done) break;
    end
    check({tag, "_done_seen"}, n < 300, 1);
  endtask

  task automatic check_d1_zero(input string tag);
    check({tag, "_busy"},  d1_busy,  0);
    check({tag, "_done"},  d1_done,  0);
    check({tag, "_rd"},    d1_rd,    0);
    check({tag, "_addr"},  d1_addr,  0);
    check({tag, "_valid"}, d1_valid, 0);
    check({tag, "_col"},   d1_col,   0);
    check({tag, "_last"},  d1_last,  0);
    check({tag, "_pos"},   {d1_band, d1_x, d1_y}, 0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    acc1 = 0; acc0 = 0; done1 = 0; done0 = 0; rdcnt1 = 0;
    rst_n = 1'b0; start1 = 1'b0; start0 = 1'b0; rdy1 = 1'b1; rdy0 = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (d1_rd) begin
          rdcnt1++;
          if (exp_a1.size() == 0) check("rd1_unexpected", 1, 0);
          else begin check("rd1_addr", d1_addr, exp_a1[0]); exp_a1.delete(0); end
        end
        if (d1_valid) begin
          if (exp_w1.size() == 0) check("win1_unexpected", 1, 0);
          else begin
            check("win1_band", d1_band, exp_w1[0].band);
            check("win1_x",    d1_x,    exp_w1[0].x);
            check("win1_y",    d1_y,    exp_w1[0].y);
            check("win1_col",  d1_col,  exp_w1[0].col);
            check("win1_last", d1_last, exp_w1[0].last);
            if (rdy1) begin exp_w1.delete(0); acc1++; end
          end
        end
        if (d1_done) done1++;
        if (d0_rd) begin
          if (exp_a0.size() == 0) check("rd0_unexpected", 1, 0);
          else begin check("rd0_addr", d0_addr, exp_a0[0]); exp_a0.delete(0); end
        end
        if (d0_valid) begin
          if (exp_w0.size() == 0) check("win0_unexpected", 1, 0);
          else begin
            check("win0_band", d0_band, exp_w0[0].band);
            check("win0_x",    d0_x,    exp_w0[0].x);
            check("win0_y",    d0_y,    exp_w0[0].y);
            check("win0_col",  d0_col,  exp_w0[0].col);
            check("win0_last", d0_last, exp_w0[0].last);
            if (rdy0) begin exp_w0.delete(0); acc0++; end
          end
        end
        if (d0_done) done0++;
      end
    join_none

    repeat (2) step();
    check_d1_zero("reset");
    check("reset_d0_busy", d0_busy, 0);
    rst_n = 1'b1;

    // Zero-pad frame, ready high; includes a start pulse while busy.
    fill(1);
    pulse_start(1);
    check("c1_busy", d1_busy, 1);
    check("c1_rd",   d1_rd,   1);
    check("c1_addr", d1_addr, 0);
    cyc = 1;
    while (cyc < 200 && !d1_done) begin
      step();
      cyc++;
      if (cyc == 2) check("c2_valid", d1_valid, 0);
      if (cyc == 3) check("c3_valid", d1_valid, 1);
      start1 = (cyc == 5);
    end
    start1 = 1'b0;
    check("f1_done_cycle", cyc, 36);
    check("f1_busy_at_done", d1_busy, 0);
    repeat (20) step();
    check("f1_idle_after", d1_busy, 0);
    check("f1_done_once", done1, 1);
    check("f1_accepted", acc1, 32);
    check("f1_win_left", exp_w1.size(), 0);
    check("f1_rd_left", exp_a1.size(), 0);

    // Same frame with the consumer stalled for 10 cycles.
    fill(1);
    acc1 = 0; done1 = 0; rdcnt1 = 0; stall_rd = 0;
    pulse_start(1);
    repeat (8) step();
    rdy1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (d1_rd) stall_rd++;
    end
    check("stall_rd_stopped", d1_rd, 0);
    check("stall_valid_held", d1_valid, 1);
    check("stall_rd_le2", stall_rd <= 2, 1);
    check("stall_buffered_le2", (rdcnt1 - acc1) <= 2, 1);
    rdy1 = 1'b1;
    wait_done(1, "f2");
    step();
    check("f2_accepted", acc1, 32);
    check("f2_done_once", done1, 1);
    check("f2_win_left", exp_w1.size(), 0);

    // Skip-rows instance.
    fill(0);
    pulse_start(0);
    wait_done(0, "f3");
    step();
    check("f3_accepted", acc0, 16);
    check("f3_done_once", done0, 1);
    check("f3_win_left", exp_w0.size(), 0);
    check("f3_rd_left", exp_a0.size(), 0);

    // Abort mid-frame, then rerun over stale line buffers.
    fill(1);
    pulse_start(1);
    repeat (15) step();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_w1.delete();
    exp_a1.delete();
    #1;
    check_d1_zero("midrst");
    repeat (3) step();
    check("midrst_valid_held", d1_valid, 0);
    rst_n = 1'b1;
    fill(1);
    acc1 = 0; done1 = 0;
    pulse_start(1);
    wait_done(1, "f4");
    step();
    check("f4_accepted", acc1, 32);
    check("f4_done_once", done1, 1);
    check("f4_win_left", exp_w1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
